fixed_mul_pipe: RTL and testbench

Pipelined, stream-handshaked signed fixed-point multiplier for the DWT lifting and quantisation datapaths. Multiplies two independently-formatted signed fixed-point operands, re-aligns the product to the output format with selectable truncation or rounding, and flags every out-of-range result. It sits between stream stages (valid/ready) and replaces the purely combinational multiplier wherever a registered, back-pressurable path is needed. Optional saturation is compiled in by macro.

---
 rtl/fixed_mul_pipe.sv | 151 +++++++++++++++
 tb/tb_fixed_mul_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fixed_mul_pipe.sv
// Pipelined valid/ready signed fixed-point multiplier with rounding,
// overflow flag and saturating overflow counter.
//
// Ports:
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   a_i, b_i, valid_i   operand stream in
//   ready_o             input accepted this cycle when valid_i is high
//   m_o, ovf_o, valid_o result stream out
//   ready_i             downstream accepts output
//   ovf_cnt_o           saturating count of delivered overflowed samples
//
// Build option: define FIXED_MUL_SAT_EN to clamp overflowed results to
// the output range. Without it, overflowed results wrap.
module fixed_mul_pipe #(
  parameter int AWidth   = 16,
  parameter int APoint   = 10,
  parameter int BWidth   = 16,
  parameter int BPoint   = 10,
  parameter int OutWidth = 16,
  parameter int OutPoint = 10,
  parameter int Stages   = 2,
  parameter int Round    = 0,
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [AWidth-1:0]   a_i,
  input  logic [BWidth-1:0]   b_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [OutWidth-1:0] m_o,
  output logic                ovf_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [CntWidth-1:0] ovf_cnt_o
);

  localparam int PW  = AWidth + BWidth;
  localparam int Lsb = APoint + BPoint - OutPoint;
  localparam int RW  = PW + 1;
  localparam int Top = OutWidth + Lsb;
  // wide enough for the rounded product and the full result field
  localparam int XW  = (RW > Top) ? RW : Top + 1;
  localparam int SW  = XW - Lsb;
  localparam int Sh  = (Lsb > 0) ? Lsb - 1 : 0;
  localparam logic [RW-1:0] RndK =
    (Round == 1 && Lsb > 0) ?
      ({{(RW-1){1'b0}}, 1'b1} << Sh) : '0;

  if (Lsb < 0) begin : g_bad_point
    $fatal(1, "APoint+BPoint must be >= OutPoint");
  end
  if (Stages < 1) begin : g_bad_stages
    $fatal(1, "Stages must be >= 1");
  end

  logic              w_adv;
  logic [PW-1:0]     w_prod;
  logic [PW-1:0]     w_last_p;
  logic              w_last_v;
  logic [RW-1:0]     w_r;
  logic [XW-1:0]     w_rx;
  logic [SW-1:0]     w_s;
  logic [SW-OutWidth:0] w_hi;
  logic              w_ovf;
  logic [OutWidth-1:0] w_m;

  logic [OutWidth-1:0] r_m;
  logic                r_ovf;
  logic                r_vo;
  logic [CntWidth-1:0] r_cnt;

  // one enable for every stage: the pipe moves only when the
  // output register is empty or being drained
  assign w_adv   = !r_vo | ready_i;
  assign ready_o = w_adv;

  assign w_prod = PW'($signed(a_i)) * PW'($signed(b_i));

  if (Stages == 1) begin : g_s1
    assign w_last_p = w_prod;
    assign w_last_v = valid_i;
  end else begin : g_sn
    logic [PW-1:0]     r_p [Stages-1];
    logic [Stages-2:0] r_v;

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        for (int i = 0; i < Stages - 1; i++) begin
          r_p[i] <= '0;
        end
        r_v <= '0;
      end else if (w_adv) begin
        r_p[0] <= w_prod;
        r_v[0] <= valid_i;
        for (int i = 1; i < Stages - 1; i++) begin
          r_p[i] <= r_p[i-1];
          r_v[i] <= r_v[i-1];
        end
      end
    end

    assign w_last_p = r_p[Stages-2];
    assign w_last_v = r_v[Stages-2];
  end

  // one extra bit so the rounding add never wraps
  assign w_r  = {w_last_p[PW-1], w_last_p} + RndK;
  assign w_rx = XW'($signed(w_r));
  assign w_s  = SW'(w_rx >> Lsb);
  // sign bit of the field plus everything above it must agree
  assign w_hi = w_s[SW-1:OutWidth-1];
  assign w_ovf = !((&w_hi) | ~(|w_hi));

  always_comb begin
    w_m = w_s[OutWidth-1:0];
`ifdef FIXED_MUL_SAT_EN
    if (w_ovf) begin
      if (w_s[SW-1]) begin
        w_m = {1'b1, {(OutWidth-1){1'b0}}};
      end else begin
        w_m = {1'b0, {(OutWidth-1){1'b1}}};
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_m   <= '0;
      r_ovf <= 1'b0;
      r_vo  <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_adv) begin
        r_m   <= w_m;
        r_ovf <= w_ovf & w_last_v;
        r_vo  <= w_last_v;
      end
      if (r_vo && ready_i && r_ovf && r_cnt != {CntWidth{1'b1}}) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign m_o       = r_m;
  assign ovf_o     = r_ovf;
  assign valid_o   = r_vo;
  assign ovf_cnt_o = r_cnt;

endmodule

// File: tb/tb_fixed_mul_pipe.sv
// Directed bench for fixed_mul_pipe: a default instance and a
// rounding instance with a 2-bit overflow counter share one stimulus.
module tb_fixed_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b;
  logic        vi, ri;

  logic        rdy0, ovf0, vo0;
  logic [15:0] m0, cnt0;
  logic        rdy1, ovf1, vo1;
  logic [15:0] m1;
  logic [1:0]  cnt1;

  int checks = 0;
  int errors = 0;

`ifdef FIXED_MUL_SAT_EN
  localparam logic [15:0] OVP = 16'h7FFF;
  localparam logic [15:0] OVN = 16'h8000;
`else
  localparam logic [15:0] OVP = 16'hF000;
  localparam logic [15:0] OVN = 16'h1000;
`endif

  always #5 clk = ~clk;

  fixed_mul_pipe u_dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .a_i(a), .b_i(b), .valid_i(vi), .ready_o(rdy0),
    .m_o(m0), .ovf_o(ovf0), .valid_o(vo0), .ready_i(ri),
    .ovf_cnt_o(cnt0)
  );

  fixed_mul_pipe #(.Round(1), .CntWidth(2)) u_dut_r (
    .clk_i(clk), .rst_n_i(rst_n),
    .a_i(a), .b_i(b), .valid_i(vi), .ready_o(rdy1),
    .m_o(m1), .ovf_o(ovf1), .valid_o(vo1), .ready_i(ri),
    .ovf_cnt_o(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] av, input logic [15:0] bv);
    a = av; b = bv; vi = 1'b1;
    step();
    vi = 1'b0;
  endtask

  initial begin
    int in_idx, out_idx;
    logic [15:0] held;
    logic stalled, acc;

    rst_n = 1'b0; a = '0; b = '0; vi = 1'b0; ri = 1'b1;
    step(); step();
    chk("rst_valid", vo0, 0);
    chk("rst_m", m0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_valid_r", vo1, 0);
    chk("rst_cnt_r", cnt1, 0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", rdy0, 1);

    // basic: 1.5 * 2.0
    send(16'h0600, 16'h0800);
    chk("basic_lat1", vo0, 0);
    step();
    chk("basic_valid", vo0, 1);
    chk("basic_m", m0, 16'h0C00);
    chk("basic_ovf", ovf0, 0);
    chk("basic_m_r", m1, 16'h0C00);
    step();
    chk("basic_once", vo0, 0);

    // overflow: +30 * 2, then -30 * 2
    send(16'h7800, 16'h0800);
    step();
    chk("ovfp_valid", vo0, 1);
    chk("ovfp_flag", ovf0, 1);
    chk("ovfp_m", m0, OVP);
    chk("ovfp_m_r", m1, OVP);
    send(16'h8800, 16'h0800);
    chk("ovfp_cnt", cnt0, 1);
    chk("ovfp_cnt_r", cnt1, 1);
    step();
    chk("ovfn_flag", ovf0, 1);
    chk("ovfn_m", m0, OVN);
    chk("ovfn_m_r", m1, OVN);
    step();
    chk("ovfn_cnt", cnt0, 2);
    chk("ovfn_cnt_r", cnt1, 2);

    // rounding: +0.5 lsb and -0.5 lsb
    send(16'h0001, 16'h0200);
    step();
    chk("rnd_pos_trunc", m0, 16'h0000);
    chk("rnd_pos_round", m1, 16'h0001);
    chk("rnd_pos_ovf", ovf1, 0);
    send(16'hFFFF, 16'h0200);
    step();
    chk("rnd_neg_trunc", m0, 16'hFFFF);
    chk("rnd_neg_round", m1, 16'h0000);
    chk("rnd_neg_ovf", ovf0, 0);
    step();

    // back-pressure: 8 samples k*1.0, ready_i low for 3 cycles
    in_idx = 0; out_idx = 0; stalled = 1'b0; held = '0;
    b = 16'h0400;
    for (int c = 0; c < 40 && out_idx < 8; c++) begin
      ri = !(c >= 4 && c <= 6);
      #1;
      if (c >= 4 && c <= 6) chk("bp_ready_low", rdy0, 0);
      if (stalled) chk("bp_stable", m0, held);
      if (vo0 && ri) begin
        chk("bp_data", m0, 32'(out_idx + 1));
        chk("bp_data_r", m1, 32'(out_idx + 1));
        out_idx++;
      end
      stalled = vo0 && !ri;
      held = m0;
      vi = (in_idx < 8);
      a = 16'(in_idx + 1);
      acc = vi && rdy0;
      @(posedge clk);
      #1;
      if (acc) in_idx++;
    end
    vi = 1'b0; ri = 1'b1;
    chk("bp_count", out_idx, 8);
    step(); step();
    chk("bp_drained", vo0, 0);

    // reset with two samples in flight
    send(16'h0400, 16'h0400);
    send(16'h0800, 16'h0400);
    chk("mr_before", vo0, 1);
    rst_n = 1'b0;
    step();
    chk("mr_valid", vo0, 0);
    chk("mr_cnt", cnt0, 0);
    chk("mr_cnt_r", cnt1, 0);
    chk("mr_m", m0, 0);
    rst_n = 1'b1;
    step();
    chk("mr_stale1", vo0, 0);
    step();
    chk("mr_stale2", vo0, 0);
    send(16'h0C00, 16'h0400);
    chk("mr_lat1", vo0, 0);
    step();
    chk("mr_lat2", vo0, 1);
    chk("mr_m_new", m0, 16'h0C00);
    step();

    // counter saturation: 5 back-to-back overflowing samples
    a = 16'h7800; b = 16'h0800; vi = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 5) vi = 1'b0;
      if (k >= 3) begin
        chk("sat_cnt", cnt0, 32'(k - 2));
        chk("sat_cnt_r", cnt1, (k - 2 > 3) ? 32'd3 : 32'(k - 2));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
